// File: rtl/uart8_transmitter_if.sv
// Transmit-side bundle of the 8N1-style UART transmitter.
//   en    : chip enable; low aborts any frame and holds the block idle
//   start : request to send, sampled only while idle
//   in    : payload word, latched when a frame is accepted
//   out   : registered tx line, idle-high
//   done  : one-clock pulse when a frame ends
//   busy  : high while a frame is in progress
// master drives the request side, slave is the transmitter.
interface uart8_transmitter_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic                 en;
    logic                 start;
    logic [DATA_BITS-1:0] in;
    logic                 out;
    logic                 done;
    logic                 busy;

    modport master (
        output en,
        output start,
        output in,
        input  out,
        input  done,
        input  busy
    );

    modport slave (
        input  en,
        input  start,
        input  in,
        output out,
        output done,
        output busy
    );
endinterface

// File: rtl/uart8_transmitter.sv
// UART transmitter: start bit, DATA_BITS payload bits LSB first, then
// STOP_BITS stop bits, each bit held for OVERSAMPLING clocks.
//   clk : oversampled baud clock (OVERSAMPLING x bit rate)
//   rst : asynchronous active-high reset
//   bus : slave side of uart8_transmitter_if (en/start/in in, out/done/busy out)
module uart8_transmitter #(
    parameter int unsigned OVERSAMPLING = 16,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    uart8_transmitter_if.slave   bus
);
    localparam int unsigned CNT_W = $clog2(OVERSAMPLING);
    localparam int unsigned IDX_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(OVERSAMPLING - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

    typedef enum logic [1:0] {
        STATE_IDLE      = 2'd0,
        STATE_START_BIT = 2'd1,
        STATE_DATA_BITS = 2'd2,
        STATE_STOP_BIT  = 2'd3
    } state_t;

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic [IDX_W-1:0]     idx;
    logic [DATA_BITS-1:0] data;
    logic                 out_r;
    logic                 busy_r;
    logic                 done_r;

    logic                 last_tick;
    logic [IDX_W-1:0]     next_idx;

    assign last_tick = (cnt == CNT_LAST);
    assign next_idx  = idx + IDX_W'(1);

    assign bus.out  = out_r;
    assign bus.busy = busy_r;
    assign bus.done = done_r;

    // Frame sequencer; idx doubles as the stop-bit counter once data is sent.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= STATE_IDLE;
            cnt    <= '0;
            idx    <= '0;
            data   <= '0;
            out_r  <= 1'b1;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (!bus.en) begin
                state  <= STATE_IDLE;
                cnt    <= '0;
                idx    <= '0;
                out_r  <= 1'b1;
                busy_r <= 1'b0;
            end else begin
                case (state)
                    STATE_IDLE: begin
                        out_r  <= 1'b1;
                        busy_r <= 1'b0;
                        if (bus.start) begin
                            data   <= bus.in;
                            out_r  <= 1'b0;
                            busy_r <= 1'b1;
                            cnt    <= '0;
                            idx    <= '0;
                            state  <= STATE_START_BIT;
                        end
                    end
                    STATE_START_BIT: begin
                        cnt <= cnt + CNT_W'(1);
                        if (last_tick) begin
                            out_r <= data[0];
                            state <= STATE_DATA_BITS;
                        end
                    end
                    STATE_DATA_BITS: begin
                        cnt <= cnt + CNT_W'(1);
                        if (last_tick) begin
                            // idx wraps to 0 after the last bit, ready to count stop bits
                            idx <= next_idx;
                            if (idx == IDX_LAST) begin
                                out_r <= 1'b1;
                                state <= STATE_STOP_BIT;
                            end else begin
                                out_r <= data[next_idx];
                            end
                        end
                    end
                    STATE_STOP_BIT: begin
                        cnt <= cnt + CNT_W'(1);
                        if (last_tick) begin
                            if (idx == STOP_LAST) begin
                                idx    <= '0;
                                busy_r <= 1'b0;
                                done_r <= 1'b1;
                                state  <= STATE_IDLE;
                            end else begin
                                idx <= next_idx;
                            end
                        end
                    end
                    default: begin
                        state  <= STATE_IDLE;
                        cnt    <= '0;
                        idx    <= '0;
                        out_r  <= 1'b1;
                        busy_r <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart8_transmitter.sv
// Scoreboard bench for uart8_transmitter: stimulus pushes expected frames,
// per-instance monitors capture the tx line while busy and compare on frame end.
// Instance 0 uses one stop bit, instance 1 uses two.
module tb_uart8_transmitter;
    localparam int OS = 16;

    typedef struct {
        int         inst;
        logic [7:0] data;
        bit         abort;
        int         len;
    } frame_t;

    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    frame_t exp_q[$];

    uart8_transmitter_if #(.DATA_BITS(8)) bus  ();
    uart8_transmitter_if #(.DATA_BITS(8)) bus2 ();

    uart8_transmitter #(.OVERSAMPLING(16), .DATA_BITS(8), .STOP_BITS(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    uart8_transmitter #(.OVERSAMPLING(16), .DATA_BITS(8), .STOP_BITS(2)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    logic [1:0] mbusy, mdone, mout;
    assign mbusy = {bus2.busy, bus.busy};
    assign mdone = {bus2.done, bus.done};
    assign mout  = {bus2.out,  bus.out};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit exp_bit(input logic [7:0] d, input int i);
        if (i < OS) return 1'b0;
        if (i < 9 * OS) return d[(i - OS) / OS];
        return 1'b1;
    endfunction

    task automatic end_frame(input int inst, input bit samples[$], input int dones);
        frame_t e;
        int     mm;
        if (exp_q.size() == 0) begin
            check_eq("unexpected_frame", inst, -1);
            return;
        end
        e = exp_q.pop_front();
        check_eq("frame_instance", inst, e.inst);
        check_eq("done_during_busy", dones, 0);
        check_eq("line_high_after_frame", int'(mout[inst]), 1);
        if (e.abort) begin
            check_eq("abort_busy_len", samples.size(), e.len);
            check_eq("abort_no_done", int'(mdone[inst]), 0);
        end else begin
            check_eq("frame_busy_len", samples.size(), (1 + 8 + inst + 1) * OS);
            check_eq("frame_done", int'(mdone[inst]), 1);
            mm = -1;
            for (int i = 0; i < samples.size(); i++) begin
                if (mm < 0 && samples[i] != exp_bit(e.data, i)) mm = i;
            end
            check_eq("frame_waveform_first_bad_clock", mm, -1);
        end
    endtask

    task automatic monitor(input int inst);
        bit samples[$];
        bit in_frame = 1'b0;
        int dones    = 0;
        forever begin
            @(negedge clk);
            if (mbusy[inst]) begin
                in_frame = 1'b1;
                samples.push_back(mout[inst]);
                if (mdone[inst]) dones++;
            end else if (in_frame) begin
                end_frame(inst, samples, dones);
                in_frame = 1'b0;
                samples.delete();
                dones = 0;
            end else if (mdone[inst]) begin
                check_eq("stray_done", int'(mdone[inst]), 0);
            end
        end
    endtask

    initial monitor(0);
    initial monitor(1);

    task automatic push_frame(input int inst, input logic [7:0] d, input bit abort, input int len);
        frame_t f;
        f.inst  = inst;
        f.data  = d;
        f.abort = abort;
        f.len   = len;
        exp_q.push_back(f);
    endtask

    // Drives a one-clock start pulse; returns at the negedge after the accepting edge.
    task automatic pulse_start(input int inst, input logic [7:0] d);
        @(negedge clk);
        if (inst == 0) begin bus.in = d; bus.start = 1'b1; end
        else begin bus2.in = d; bus2.start = 1'b1; end
        @(negedge clk);
        bus.start  = 1'b0;
        bus2.start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || mbusy != 2'b00) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_eq("drain_within_budget", int'(n < budget), 1);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int n;
        rst       = 1'b1;
        bus.en    = 1'b1;
        bus.start = 1'b1;
        bus.in    = 8'hA5;
        bus2.en    = 1'b1;
        bus2.start = 1'b0;
        bus2.in    = 8'h00;

        // Reset values, with start already requested
        #12;
        check_eq("rst_out",   int'(bus.out),   1);
        check_eq("rst_busy",  int'(bus.busy),  0);
        check_eq("rst_done",  int'(bus.done),  0);
        check_eq("rst_out2",  int'(bus2.out),  1);
        check_eq("rst_busy2", int'(bus2.busy), 0);

        // First edge after reset accepts 0xA5
        push_frame(0, 8'hA5, 1'b0, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_eq("accept_after_reset", int'(bus.busy), 1);
        check_eq("start_bit_first_clock", int'(bus.out), 0);
        bus.start = 1'b0;
        wait_idle(400);

        // Back-to-back: start held, 0x00 then 0xFF
        push_frame(0, 8'h00, 1'b0, 0);
        push_frame(0, 8'hFF, 1'b0, 0);
        @(negedge clk);
        bus.in = 8'h00;
        bus.start = 1'b1;
        @(negedge clk);
        bus.in = 8'hFF;
        n = 0;
        while (!bus.done && n < 300) begin
            @(negedge clk);
            n++;
        end
        check_eq("b2b_first_done_seen", int'(bus.done), 1);
        check_eq("b2b_gap_line_high", int'(bus.out), 1);
        @(negedge clk);
        check_eq("b2b_second_busy", int'(bus.busy), 1);
        check_eq("b2b_second_start_bit", int'(bus.out), 0);
        bus.start = 1'b0;
        wait_idle(400);

        // Input stability during a 0x3C frame
        push_frame(0, 8'h3C, 1'b0, 0);
        pulse_start(0, 8'h3C);
        for (int i = 0; i < 10; i++) begin
            repeat (13) @(negedge clk);
            bus.in = 8'(8'h11 * (i + 1));
            bus.start = 1'b1;
            @(negedge clk);
            bus.start = 1'b0;
        end
        wait_idle(400);
        repeat (20) @(negedge clk);
        check_eq("no_extra_frame", int'(bus.busy), 0);

        // en=0 with start=1 in idle stays idle
        @(negedge clk);
        bus.en = 1'b0;
        bus.start = 1'b1;
        bus.in = 8'h99;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("en_low_stays_idle", int'(bus.busy), 0);
        end
        bus.start = 1'b0;
        bus.en = 1'b1;
        repeat (2) @(negedge clk);

        // Enable abort at clock 50, then a clean 0x81 frame
        push_frame(0, 8'hF0, 1'b1, 50);
        pulse_start(0, 8'hF0);
        repeat (49) @(negedge clk);
        bus.en = 1'b0;
        @(negedge clk);
        check_eq("abort_busy_low", int'(bus.busy), 0);
        check_eq("abort_out_high", int'(bus.out), 1);
        bus.en = 1'b1;
        wait_idle(100);
        push_frame(0, 8'h81, 1'b0, 0);
        pulse_start(0, 8'h81);
        wait_idle(400);

        // Asynchronous reset between edges at clock 70, then 0x5A
        push_frame(0, 8'hC3, 1'b1, 70);
        pulse_start(0, 8'hC3);
        repeat (69) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check_eq("async_rst_out", int'(bus.out), 1);
        check_eq("async_rst_busy", int'(bus.busy), 0);
        check_eq("async_rst_done", int'(bus.done), 0);
        #1 rst = 1'b0;
        wait_idle(100);
        push_frame(0, 8'h5A, 1'b0, 0);
        pulse_start(0, 8'h5A);
        wait_idle(400);

        // Two stop bits on the second instance
        push_frame(1, 8'h55, 1'b0, 0);
        pulse_start(1, 8'h55);
        wait_idle(400);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
